// File: rtl/axi4lite_cmd_master.sv
// AXI4-Lite initiator: turns single-beat fabric commands into AXI4-Lite
// transactions and returns each completion on a response handshake.
`timescale 1ns/1ps
module axi4lite_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic [7:0]              err_count,
   output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]              M_AXI_AWPROT,
   output logic                    M_AXI_AWVALID,
   input  logic                    M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                    M_AXI_WVALID,
   input  logic                    M_AXI_WREADY,
   input  logic [1:0]              M_AXI_BRESP,
   input  logic                    M_AXI_BVALID,
   output logic                    M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]              M_AXI_ARPROT,
   output logic                    M_AXI_ARVALID,
   input  logic                    M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]              M_AXI_RRESP,
   input  logic                    M_AXI_RVALID,
   output logic                    M_AXI_RREADY
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR      = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD_ADDR = 3'd3;
   localparam logic [2:0] S_RD_DATA = 3'd4;
   localparam logic [2:0] S_RSP     = 3'd5;

   logic [2:0]              state;
   logic                    aw_done;
   logic                    w_done;
   logic                    write_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] wstrb_q;

   logic       aw_hs;
   logic       w_hs;
   logic       b_hs;
   logic       r_hs;
   logic [1:0] cap_resp;

   assign aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs     = M_AXI_WVALID && M_AXI_WREADY;
   assign b_hs     = (state == S_WR_RESP) && M_AXI_BVALID && M_AXI_BREADY;
   assign r_hs     = (state == S_RD_DATA) && M_AXI_RVALID && M_AXI_RREADY;
   assign cap_resp = b_hs ? M_AXI_BRESP : M_AXI_RRESP;

   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;
   assign M_AXI_AWADDR = addr_q;
   assign M_AXI_ARADDR = addr_q;
   assign M_AXI_WDATA  = wdata_q;
   assign M_AXI_WSTRB  = wstrb_q;

   // Transaction sequencer: one command in flight, all outputs registered.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state         <= S_IDLE;
         cmd_ready     <= 1'b0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         write_q       <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_write     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b00;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  write_q   <= cmd_write;
                  addr_q    <= cmd_addr;
                  wdata_q   <= cmd_wdata;
                  wstrb_q   <= cmd_wstrb;
                  if (cmd_write) begin
                     state         <= S_WR;
                     M_AXI_AWVALID <= 1'b1;
                     M_AXI_WVALID  <= 1'b1;
                     aw_done       <= 1'b0;
                     w_done        <= 1'b0;
                  end else begin
                     state         <= S_RD_ADDR;
                     M_AXI_ARVALID <= 1'b1;
                  end
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            S_WR: begin
               if (aw_hs) begin
                  M_AXI_AWVALID <= 1'b0;
                  aw_done       <= 1'b1;
               end
               if (w_hs) begin
                  M_AXI_WVALID <= 1'b0;
                  w_done       <= 1'b1;
               end
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  state        <= S_WR_RESP;
                  M_AXI_BREADY <= 1'b1;
               end
            end
            S_WR_RESP: begin
               if (b_hs) begin
                  M_AXI_BREADY <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_write    <= write_q;
                  rsp_rdata    <= '0;
                  rsp_resp     <= M_AXI_BRESP;
                  state        <= S_RSP;
               end
            end
            S_RD_ADDR: begin
               if (M_AXI_ARREADY) begin
                  M_AXI_ARVALID <= 1'b0;
                  M_AXI_RREADY  <= 1'b1;
                  state         <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (r_hs) begin
                  M_AXI_RREADY <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_write    <= write_q;
                  rsp_rdata    <= M_AXI_RDATA;
                  rsp_resp     <= M_AXI_RRESP;
                  state        <= S_RSP;
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Saturating tally of non-OKAY responses as they are captured.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         err_count <= 8'd0;
      end else if ((b_hs || r_hs) && (cap_resp != 2'b00)
                   && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Directed + randomized bench for axi4lite_cmd_master with a word-memory
// slave model and a saturating error-count model.
`timescale 1ns/1ps
module tb_axi4lite_cmd_master;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [7:0]  err_count;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int errors = 0;
   int checks = 0;
   int exp_err = 0;
   logic [31:0] mem [0:15];

   always #5 aclk = ~aclk;

   axi4lite_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .err_count(err_count),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
      .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
      .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
      .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic slave_idle();
      awready = 1'b0; wready = 1'b0;
      bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0;
      rdata = 32'h0; rresp = 2'b00;
      rsp_ready = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_awvalid"}, 32'(awvalid), 32'd0);
      chk({tag, "_wvalid"}, 32'(wvalid), 32'd0);
      chk({tag, "_bready"}, 32'(bready), 32'd0);
      chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
      chk({tag, "_rready"}, 32'(rready), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_write"}, 32'(rsp_write), 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_rsp_resp"}, 32'(rsp_resp), 32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   // One command against a slave whose ready/valid timing is given as
   // cycle counts after acceptance; for reads ad is the AR delay.
   task automatic run_txn(input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input int ad, input int wd, input int bd,
                          input int rd, input int pd,
                          input logic [1:0] resp);
      logic [31:0] exp_rdata;
      int idx, k, rsp_k, avc, wvc, arc, waitc;
      bit aw_seen, w_seen, b_seen, ar_seen, done;
      bit aw_hs, w_hs, b_hs, ar_hs, p_hs;
      idx = int'(addr[5:2]);
      exp_rdata = wr ? 32'h0 : mem[idx];
      if (wr)
         for (int b = 0; b < 4; b++)
            if (strb[b]) mem[idx][8*b +: 8] = data[8*b +: 8];
      if (resp != 2'b00 && exp_err < 255) exp_err++;
      waitc = 0;
      while (!cmd_ready && waitc < 20) begin
         @(posedge aclk); #1; waitc++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
      cmd_wdata = data; cmd_wstrb = strb;
      @(posedge aclk); #1;
      cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = $urandom;
      cmd_wstrb = 4'(~strb);
      k = 1; rsp_k = 0; avc = 0; wvc = 0; arc = 0;
      aw_seen = 0; w_seen = 0; b_seen = 0; ar_seen = 0; done = 0;
      while (!done && k < 200) begin
         awready = wr && (k > ad);
         wready = wr && (k > wd);
         bvalid = wr && (k > bd) && !b_seen;
         bresp = bvalid ? resp : 2'b00;
         arready = !wr && (k > ad);
         rvalid = !wr && (k > ad + rd);
         rdata = rvalid ? exp_rdata : 32'h0;
         rresp = rvalid ? resp : 2'b00;
         rsp_ready = (pd == 0) || (rsp_k != 0 && k >= rsp_k + pd);
         chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
         if (awvalid) begin
            avc++;
            chk("aw_reissue", 32'(aw_seen || !wr), 32'd0);
            chk("awaddr", awaddr, addr);
            chk("awprot", 32'(awprot), 32'd0);
         end
         if (wvalid) begin
            wvc++;
            chk("w_reissue", 32'(w_seen || !wr), 32'd0);
            chk("wdata", wdata, data);
            chk("wstrb", 32'(wstrb), 32'(strb));
         end
         if (bready)
            chk("bready_early", 32'(aw_seen && w_seen), 32'd1);
         if (arvalid) begin
            arc++;
            chk("ar_reissue", 32'(ar_seen || wr), 32'd0);
            chk("araddr", araddr, addr);
            chk("arprot", 32'(arprot), 32'd0);
         end
         if (rready)
            chk("rready_early", 32'(ar_seen), 32'd1);
         if (rsp_valid) begin
            if (rsp_k == 0) rsp_k = k;
            chk("rsp_write", 32'(rsp_write), 32'(wr));
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_resp", 32'(rsp_resp), 32'(resp));
            chk("err_count", 32'(err_count), 32'(exp_err));
         end
         aw_hs = awvalid && awready;
         w_hs = wvalid && wready;
         b_hs = bvalid && bready;
         ar_hs = arvalid && arready;
         p_hs = rsp_valid && rsp_ready;
         @(posedge aclk); #1;
         k++;
         if (aw_hs) aw_seen = 1;
         if (w_hs) w_seen = 1;
         if (b_hs) b_seen = 1;
         if (ar_hs) ar_seen = 1;
         if (p_hs) done = 1;
      end
      chk("txn_timeout", 32'(done), 32'd1);
      chk("rsp_dropped", 32'(rsp_valid), 32'd0);
      chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
      if (wr) begin
         chk("aw_cycles", 32'(avc), 32'(ad + 1));
         chk("w_cycles", 32'(wvc), 32'(wd + 1));
      end else begin
         chk("ar_cycles", 32'(arc), 32'(ad + 1));
      end
      if (ad == 0 && wd == 0 && bd == 0 && rd == 0 && pd == 0)
         chk("rsp_latency", 32'(rsp_k), 32'd3);
      slave_idle();
   endtask

   initial begin
      logic [1:0] r;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      aresetn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
      cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
      slave_idle();
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk_quiet("rst");
      aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("release_cmd_ready", 32'(cmd_ready), 32'd1);

      run_txn(1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00);
      run_txn(1, 32'hC, 32'h00000001, 4'hF, 1, 4, 0, 0, 0, 2'b00);
      run_txn(0, 32'hC, 32'h0, 4'h0, 2, 0, 0, 4, 0, 2'b00);
      run_txn(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 1, 5, 2'b10);
      chk("err_after_one", 32'(err_count), 32'd1);

      for (int i = 0; i < 60; i++) begin
         r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         run_txn(1'($urandom_range(0, 1)),
                 {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                 $urandom, 4'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 5),
                 $urandom_range(0, 3), $urandom_range(0, 2), r);
      end

      for (int i = 0; i < 300; i++)
         run_txn(1'($urandom_range(0, 1)),
                 {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                 $urandom, 4'($urandom), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 2),
                 $urandom_range(0, 1), 0, 2'($urandom_range(1, 3)));
      chk("err_saturated", 32'(err_count), 32'd255);

      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8;
      cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
      @(posedge aclk); #1;
      cmd_valid = 1'b0;
      @(posedge aclk); #1;
      chk("midwr_awvalid", 32'(awvalid), 32'd1);
      chk("midwr_wvalid", 32'(wvalid), 32'd1);
      aresetn = 1'b0;
      exp_err = 0;
      @(posedge aclk); #1;
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk_quiet("midrst");
      aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("midrel_cmd_ready", 32'(cmd_ready), 32'd1);
      chk_quiet("midrel");
      run_txn(0, 32'h4, 32'h0, 4'h0, 1, 0, 0, 2, 1, 2'b00);
      chk("final_err", 32'(err_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi4lite_cmd_master.md
Name: axi4lite_cmd_master

Overview:
- AXI4-Lite initiator, the counterpart of the fabric register slaves. It turns single-beat commands (write address/data/strobe, or read address) from fabric logic into AXI4-Lite transactions toward a slave.
- It returns each transaction's completion (read data, response code) on a response handshake.
- Typical use: drive S_MASK_ADDR/S_MASK_DATA/S_MASK_VALID-style outputs of one block into the AXI-Lite slave port of another.
- One outstanding transaction at a time; strictly in order.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; strobe width is DATA_WIDTH/8.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes (ignored for reads).
- rsp_valid  out  1  completion present.
- rsp_ready  in  1  completion consumed.
- rsp_write  out  1  completion belongs to a write.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
- rsp_resp  out  2  BRESP or RRESP of the transaction.
- err_count  out  8  saturating count of non-OKAY responses.
- M_AXI_AWADDR  out  ADDR_WIDTH;  M_AXI_AWPROT  out  3;  M_AXI_AWVALID  out  1;  M_AXI_AWREADY  in  1.
- M_AXI_WDATA  out  DATA_WIDTH;  M_AXI_WSTRB  out  DATA_WIDTH/8;  M_AXI_WVALID  out  1;  M_AXI_WREADY  in  1.
- M_AXI_BRESP  in  2;  M_AXI_BVALID  in  1;  M_AXI_BREADY  out  1.
- M_AXI_ARADDR  out  ADDR_WIDTH;  M_AXI_ARPROT  out  3;  M_AXI_ARVALID  out  1;  M_AXI_ARREADY  in  1.
- M_AXI_RDATA  in  DATA_WIDTH;  M_AXI_RRESP  in  2;  M_AXI_RVALID  in  1;  M_AXI_RREADY  out  1.

Behaviour:
- Clocking/reset: one clock aclk; reset aresetn is synchronous and active-low.
  - When aresetn is sampled low at a rising edge: state=IDLE; all AXI VALID/READY outputs 0; cmd_ready=0; rsp_valid=0; rsp_write=0, rsp_rdata=0, rsp_resp=0; err_count=0; address/data/strobe registers 0.
  - A reset mid-transaction abandons the transaction; no response is issued.
- AWPROT and ARPROT are tied to 3'b000. All AXI and rsp outputs are registered.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1 starting from the first cycle after reset is released.
  - On accept: latch addr, wdata, wstrb and write; drop cmd_ready next cycle.
  - write=1 goes to WR with AWVALID=1 and WVALID=1 in the next cycle.
  - write=0 goes to RD_ADDR with ARVALID=1 in the next cycle.
- WR:
  - AW and W are independent. Each VALID holds, with stable payload, until its own READY is sampled high, then drops on the next cycle.
  - Track aw_done and w_done. Same-cycle handshakes on both channels are legal.
  - When both are done, go to WR_RESP with BREADY=1.
  - BVALID arriving before both handshakes complete waits (BREADY=0).
- WR_RESP: on BVALID && BREADY, capture BRESP, set rsp_write=1, set rsp_rdata=0, drop BREADY, go to RSP.
- RD_ADDR: ARVALID holds until ARREADY, then go to RD_DATA with RREADY=1.
- RD_DATA: on RVALID && RREADY, capture RDATA and RRESP, set rsp_write=0, drop RREADY, go to RSP.
- RSP:
  - rsp_valid=1 with payload stable until rsp_ready is sampled high.
  - Then rsp_valid=0, go to IDLE, cmd_ready=1 on the following cycle.
  - rsp_ready may be high before rsp_valid; completion still takes 1 cycle in RSP.
- Latency (zero-wait slave, rsp_ready=1), in cycles after the accept edge:
  - Write: AW/W valid at +1; BREADY at +2; B handshake at +2 if BVALID is already high; rsp_valid at +3; next cmd_ready at +4.
  - Read: ARVALID at +1; RREADY at +2; rsp_valid at +3.
- err_count increments by 1 when a response with resp != 2'b00 is captured. It saturates at 255 and clears only on reset.
- The block never issues a new AW, W or AR while a transaction is in progress. cmd_valid is ignored outside IDLE.

Test Plan:
- Write, zero-wait slave: cmd write, addr 0x4, data 0xDEADBEEF, strb 0xF.
  - AWADDR=0x4 and WDATA=0xDEADBEEF are valid together for 1 cycle.
  - rsp_valid=1, rsp_write=1, rsp_resp=0, rsp_rdata=0; err_count=0.
- Skewed write channels: WREADY 3 cycles after AWREADY, BVALID asserted early.
  - AWVALID drops after its handshake; WVALID holds with stable data until WREADY.
  - BREADY rises only after both handshakes; a single response is returned.
- Read: addr 0xC; slave ARREADY after 2 cycles, RDATA=0x00000001 after 4 more.
  - ARVALID holds 3 cycles; rsp_rdata=0x1, rsp_write=0, rsp_resp=0.
- Error/backpressure: read returns RRESP=2'b10 and rsp_ready is held 0 for 5 cycles.
  - rsp_valid holds with stable payload; cmd_ready stays 0; err_count goes 0 to 1.
  - Repeat 300 times: err_count stops at 255.
- Reset mid-write: aresetn low while AWVALID=1 and WVALID=1.
  - Next edge: all VALID/READY=0, rsp_valid=0, err_count=0.
  - cmd_ready=1 on the first cycle after release; a new read completes normally.
